// File: rtl/audio_pdm_out.sv
// Final audio output stage: strobe capture, soft-mute gain ramp and first-order sigma-delta PDM.
// Define AUDIO_PDM_SOFT_MUTE_EN for the ramped gain; otherwise mute switches gain instantly.
module audio_pdm_out #(
  parameter int unsigned SAMPLE_WIDTH = 12
) (
  input  logic                           main_clk,
  input  logic                           rst,
  input  logic                           sample_clk,
  input  logic signed [SAMPLE_WIDTH-1:0] din,
  input  logic                           mute,
  output logic                           pdm_out,
  output logic                           muted
);

  localparam int unsigned W = SAMPLE_WIDTH;
  localparam logic [8:0] GainFull = 9'd256;

  typedef enum logic [1:0] {StMuted, StRampUp, StPlaying, StRampDown} state_e;

  state_e               state_q;
  logic                 sclk_q;
  logic signed [W-1:0]  sample_q;
  logic [8:0]           gain_q;
  logic [W-1:0]         acc_q;

  logic                 strobe;
  logic signed [W+9:0]  product;
  logic [W-1:0]         scaled;
  logic [W-1:0]         u;
  logic [W:0]           sum;
  logic                 unused_product;

  assign strobe  = sample_clk & ~sclk_q;

  // gain <= 256 keeps the shifted product inside W bits, so the top bits are sign copies.
  assign product = sample_q * $signed({1'b0, gain_q});
  assign scaled  = product[W+7:8];
  assign unused_product = ^{product[W+9:W+8], product[7:0]};

  assign u   = {~scaled[W-1], scaled[W-2:0]};
  assign sum = {1'b0, acc_q} + {1'b0, u};

  always_ff @(posedge main_clk) begin
    if (rst) begin
      sclk_q   <= 1'b0;
      sample_q <= '0;
      gain_q   <= '0;
      state_q  <= StMuted;
      acc_q    <= '0;
      pdm_out  <= 1'b0;
      muted    <= 1'b1;
    end else begin
      sclk_q  <= sample_clk;
      acc_q   <= sum[W-1:0];
      pdm_out <= sum[W];
      if (strobe) sample_q <= din;

`ifdef AUDIO_PDM_SOFT_MUTE_EN
      // A direction change always wins over a coincident gain step.
      unique case (state_q)
        StMuted: begin
          gain_q <= '0;
          if (!mute) begin
            state_q <= StRampUp;
            muted   <= 1'b0;
          end
        end
        StRampUp: begin
          if (mute) begin
            state_q <= StRampDown;
          end else if (gain_q == GainFull) begin
            state_q <= StPlaying;
          end else if (strobe) begin
            gain_q <= gain_q + 9'd1;
            if (gain_q == GainFull - 9'd1) state_q <= StPlaying;
          end
        end
        StPlaying: begin
          gain_q <= GainFull;
          if (mute) state_q <= StRampDown;
        end
        StRampDown: begin
          if (!mute) begin
            state_q <= StRampUp;
          end else if (gain_q == 9'd0) begin
            state_q <= StMuted;
            muted   <= 1'b1;
          end else if (strobe) begin
            gain_q <= gain_q - 9'd1;
            if (gain_q == 9'd1) begin
              state_q <= StMuted;
              muted   <= 1'b1;
            end
          end
        end
        default: begin
          state_q <= StMuted;
          gain_q  <= '0;
          muted   <= 1'b1;
        end
      endcase
`else
      unique case (state_q)
        StMuted: begin
          gain_q <= '0;
          if (!mute) begin
            state_q <= StPlaying;
            gain_q  <= GainFull;
            muted   <= 1'b0;
          end
        end
        StPlaying: begin
          gain_q <= GainFull;
          if (mute) begin
            state_q <= StMuted;
            gain_q  <= '0;
            muted   <= 1'b1;
          end
        end
        default: begin
          state_q <= StMuted;
          gain_q  <= '0;
          muted   <= 1'b1;
        end
      endcase
`endif
    end
  end

endmodule
